// File: rtl/ad9783_spi_responder.sv
// SPI mode-0 responder for 16-bit AD9783-style frames, backed by a 32x8 register file; pins oversampled on clk_in.
// Define AD9783_SPI_STREAM_EN for multi-byte frames (n+1 bytes, decrementing address).
`timescale 1ns/1ps
module ad9783_spi_responder #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] REG_RESET   = 8'h00,
  parameter logic [4:0] STATUS_ADDR = 5'h1F
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       spi_scs_in,
  input  logic       spi_sck_in,
  input  logic       spi_sdi_in,
  output logic       spi_sdo_out,
  output logic       spi_sdo_oe_out,
  input  logic [7:0] status_in,
  output logic       reg_wr_strb_out,
  output logic [4:0] reg_wr_addr_out,
  output logic [7:0] reg_wr_data_out,
  input  logic [4:0] host_rd_addr_in,
  output logic [7:0] host_rd_data_out,
  output logic       busy_out,
  output logic       err_out
);

  typedef enum logic [1:0] {IDLE, INSTR, DATA, DONE} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] scs_sync, sck_sync, sdi_sync;
  logic                   scs_d, sck_d;
  logic                   scs_s, sck_s, sdi_s;
  logic                   scs_rise, scs_fall, sck_rise, sck_fall;

  logic [7:0] regs [32];
  logic [6:0] shift_in;
  logic [2:0] bit_cnt;
  logic       rw;
  logic [4:0] addr;
  logic [7:0] sdo_sh;
  logic       sdo_oe;
  logic       last_byte;
  logic [4:0] instr_addr;
  logic [7:0] rd_instr;
  logic [7:0] wr_byte;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      scs_sync <= '1;
      scs_d    <= 1'b1;
      sck_sync <= '0;
      sck_d    <= 1'b0;
      sdi_sync <= '0;
    end else begin
      scs_sync <= {scs_sync[SYNC_STAGES-2:0], spi_scs_in};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_sck_in};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi_in};
      scs_d    <= scs_sync[SYNC_STAGES-1];
      sck_d    <= sck_sync[SYNC_STAGES-1];
    end
  end

  assign scs_s    = scs_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync[SYNC_STAGES-1];
  assign scs_rise = scs_s & ~scs_d;
  assign scs_fall = ~scs_s & scs_d;
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;

  assign instr_addr = {shift_in[3:0], sdi_s};
  assign rd_instr   = (instr_addr == STATUS_ADDR) ? status_in : regs[instr_addr];
  assign wr_byte    = {shift_in, sdi_s};

`ifdef AD9783_SPI_STREAM_EN
  logic [1:0] byte_cnt;
  logic [4:0] next_addr;
  logic [7:0] rd_next;
  assign last_byte = (byte_cnt == 2'd0);
  assign next_addr = addr - 5'd1;
  assign rd_next   = (next_addr == STATUS_ADDR) ? status_in : regs[next_addr];
`else
  assign last_byte = 1'b1;
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (scs_fall) state_nxt = INSTR;
      INSTR: if (scs_rise) state_nxt = IDLE;
             else if (sck_rise && bit_cnt == 3'd7) state_nxt = DATA;
      DATA:  if (scs_rise) state_nxt = IDLE;
             else if (sck_rise && bit_cnt == 3'd7 && last_byte) state_nxt = DONE;
      DONE:  if (scs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_out       = (state != IDLE);
    spi_sdo_oe_out = sdo_oe;
    spi_sdo_out    = sdo_oe & sdo_sh[7];
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      bit_cnt          <= 3'd0;
      shift_in         <= 7'd0;
      rw               <= 1'b0;
      addr             <= 5'd0;
      sdo_sh           <= 8'd0;
      sdo_oe           <= 1'b0;
      reg_wr_strb_out  <= 1'b0;
      reg_wr_addr_out  <= 5'd0;
      reg_wr_data_out  <= 8'd0;
      err_out          <= 1'b0;
      host_rd_data_out <= 8'd0;
      for (int i = 0; i < 32; i++) regs[i] <= REG_RESET;
`ifdef AD9783_SPI_STREAM_EN
      byte_cnt         <= 2'd0;
`endif
    end else begin
      reg_wr_strb_out  <= 1'b0;
      err_out          <= 1'b0;
      // Old contents on a same-cycle SPI write: NBA ordering gives read-before-write.
      host_rd_data_out <= regs[host_rd_addr_in];
      if (scs_rise) begin
        sdo_oe <= 1'b0;
        if (state == INSTR || state == DATA) err_out <= 1'b1;
      end else begin
        case (state)
          IDLE: if (scs_fall) begin
            bit_cnt <= 3'd0;
            sdo_oe  <= 1'b0;
          end
          INSTR: if (sck_rise) begin
            shift_in <= {shift_in[5:0], sdi_s};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rw   <= shift_in[6];
              addr <= instr_addr;
`ifdef AD9783_SPI_STREAM_EN
              byte_cnt <= shift_in[5:4];
`endif
              if (shift_in[6]) begin
                sdo_sh <= rd_instr;
                sdo_oe <= 1'b1;
              end
            end
          end
          DATA: if (sck_rise) begin
            shift_in <= {shift_in[5:0], sdi_s};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (!rw && addr != STATUS_ADDR) begin
                regs[addr]      <= wr_byte;
                reg_wr_strb_out <= 1'b1;
                reg_wr_addr_out <= addr;
                reg_wr_data_out <= wr_byte;
              end
              if (last_byte) sdo_oe <= 1'b0;
`ifdef AD9783_SPI_STREAM_EN
              else begin
                addr     <= next_addr;
                byte_cnt <= byte_cnt - 2'd1;
                if (rw) sdo_sh <= rd_next;
              end
`endif
            end
          // bit7 must stay valid through the first data rise, so no shift before it
          end else if (sck_fall && rw && bit_cnt != 3'd0) begin
            sdo_sh <= {sdo_sh[6:0], 1'b0};
          end
          default: ;
        endcase
      end
    end
  end

endmodule
